// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a byte-wide data memory between two word requesters.
// Port 0 is the processor load/store path, port 1 the loader/debug path.
// A granted word access runs as four big-endian byte beats: the byte at the
// base address carries bits 31:24. All outputs are registered.
module dmem_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              done0,
  output logic              done1,
  output logic [31:0]       rdata0,
  output logic [31:0]       rdata1,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r;
  logic                owner_r;   // 0 = port 0, 1 = port 1
  logic                we_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [31:0]         wdata_r;
  logic [1:0]          beat_r;
  logic [23:0]         acc_r;     // first three read bytes, oldest in the top byte
  logic                last_r;    // port served most recently

  logic                win_s;
  logic                sel_we_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [31:0]         sel_wdata_s;
  logic [1:0]          beat_nxt_s;

  // Byte of a word driven on a given beat; beat 0 is the most significant byte.
  function automatic logic [7:0] beat_byte(input logic [31:0] w, input logic [1:0] b);
    case (b)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      2'd3:    return w[7:0];
      default: return 8'h00;
    endcase
  endfunction

  // Pick the winner of the IDLE arbitration and mux its request fields.
  always_comb begin
    win_s = 1'b0;
    if (req0 && req1) begin
      if (FIXED_PRIO != 0) begin
        win_s = 1'b0;
      end else begin
        win_s = ~last_r;
      end
    end else if (req1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    if (win_s) begin
      sel_we_s    = we1;
      sel_addr_s  = addr1;
      sel_wdata_s = wdata1;
    end else begin
      sel_we_s    = we0;
      sel_addr_s  = addr0;
      sel_wdata_s = wdata0;
    end
    beat_nxt_s = beat_r + 2'd1;
  end

  // Access sequencer: latch the winner, run four byte beats, pulse done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      owner_r   <= 1'b0;
      we_r      <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= 32'h0000_0000;
      beat_r    <= 2'd0;
      acc_r     <= 24'h00_0000;
      last_r    <= 1'b1;
      gnt       <= 2'b00;
      busy      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      rdata0    <= 32'h0000_0000;
      rdata1    <= 32'h0000_0000;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          if (req0 || req1) begin
            state_r   <= XFER;
            owner_r   <= win_s;
            we_r      <= sel_we_s;
            addr_r    <= sel_addr_s;
            wdata_r   <= sel_wdata_s;
            beat_r    <= 2'd0;
            acc_r     <= 24'h00_0000;
            gnt       <= win_s ? 2'b10 : 2'b01;
            busy      <= 1'b1;
            // Beat 0 is presented straight from the winning port's fields.
            mem_addr  <= sel_addr_s;
            mem_we    <= sel_we_s;
            mem_wdata <= sel_we_s ? sel_wdata_s[31:24] : 8'h00;
          end
        end
        XFER: begin
          if (!we_r) begin
            acc_r <= {acc_r[15:0], mem_rdata};
          end
          if (beat_r == 2'd3) begin
            state_r   <= DONE;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= 8'h00;
            if (owner_r) begin
              done1 <= 1'b1;
              if (!we_r) begin
                rdata1 <= {acc_r, mem_rdata};
              end
            end else begin
              done0 <= 1'b1;
              if (!we_r) begin
                rdata0 <= {acc_r, mem_rdata};
              end
            end
          end else begin
            beat_r    <= beat_nxt_s;
            // Sum is truncated to ADDR_W bits, so the top address wraps to 0.
            mem_addr  <= addr_r + ADDR_W'(beat_nxt_s);
            mem_we    <= we_r;
            mem_wdata <= we_r ? beat_byte(wdata_r, beat_nxt_s) : 8'h00;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done0   <= 1'b0;
          done1   <= 1'b0;
          gnt     <= 2'b00;
          busy    <= 1'b0;
          beat_r  <= 2'd0;
          last_r  <= owner_r;
        end
        default: begin
          state_r   <= IDLE;
          gnt       <= 2'b00;
          busy      <= 1'b0;
          done0     <= 1'b0;
          done1     <= 1'b0;
          mem_addr  <= '0;
          mem_we    <= 1'b0;
          mem_wdata <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a round-robin instance driven through
// a scoreboard, plus a fixed-priority instance for the port-0 priority case.
module tb_dmem_arbiter;

  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Round-robin instance signals
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [31:0]   wdata0, wdata1;
  logic          done0, done1;
  logic [31:0]   rdata0, rdata1;
  logic [1:0]    gnt;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata, mem_rdata;
  logic [7:0]    mem [0:31] = '{default: 8'h00};

  // Fixed-priority instance signals
  logic          f_req0, f_req1, f_we0, f_we1;
  logic [AW-1:0] f_addr0, f_addr1;
  logic [31:0]   f_wdata0, f_wdata1;
  logic          f_done0, f_done1;
  logic [31:0]   f_rdata0, f_rdata1;
  logic [1:0]    f_gnt;
  logic          f_busy;
  logic [AW-1:0] f_mem_addr;
  logic          f_mem_we;
  logic [7:0]    f_mem_wdata, f_mem_rdata;
  logic [7:0]    fmem [0:31] = '{default: 8'h00};

  dmem_arbiter #(.ADDR_W(AW), .FIXED_PRIO(0)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
    .gnt(gnt), .busy(busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(AW), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .reset(reset),
    .req0(f_req0), .req1(f_req1), .we0(f_we0), .we1(f_we1),
    .addr0(f_addr0), .addr1(f_addr1), .wdata0(f_wdata0), .wdata1(f_wdata1),
    .done0(f_done0), .done1(f_done1), .rdata0(f_rdata0), .rdata1(f_rdata1),
    .gnt(f_gnt), .busy(f_busy),
    .mem_addr(f_mem_addr), .mem_we(f_mem_we), .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata)
  );

  // Byte memories: synchronous write, combinational read
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (f_mem_we) fmem[f_mem_addr] <= f_mem_wdata;
  end
  assign mem_rdata   = mem[mem_addr];
  assign f_mem_rdata = fmem[f_mem_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: one entry per access in expected service order
  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [7:0]  ref_mem [0:31] = '{default: 8'h00};
  logic [31:0] exp_rd0 = 32'h0;
  logic [31:0] exp_rd1 = 32'h0;

  task automatic sb_push(input logic p, input logic w, input logic [AW-1:0] a, input logic [31:0] d);
    exp_t e;
    logic [31:0] word;
    logic [AW-1:0] ak;
    word = 32'h0;
    for (int k = 0; k < 4; k++) begin
      ak = a + AW'(k);
      if (w) ref_mem[ak] = d[31-8*k -: 8];
      word = {word[23:0], ref_mem[ak]};
    end
    e.port = p;
    e.we   = w;
    e.addr = a;
    e.data = w ? d : word;
    sb_q.push_back(e);
  endtask

  // Monitor: pop the scoreboard on each done pulse and compare the result
  initial begin
    logic [AW-1:0] ak;
    forever begin
      @(negedge clk);
      if (!reset && (done0 || done1)) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'({done1, done0}), 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("sb_done_port", 32'({done1, done0}), mon_e.port ? 32'd2 : 32'd1);
          if (mon_e.we) begin
            for (int k = 0; k < 4; k++) begin
              ak = mon_e.addr + AW'(k);
              check("sb_mem_byte", 32'(mem[ak]), 32'(mon_e.data[31-8*k -: 8]));
            end
          end else begin
            if (mon_e.port) exp_rd1 = mon_e.data;
            else            exp_rd0 = mon_e.data;
          end
          check("sb_rdata0", rdata0, exp_rd0);
          check("sb_rdata1", rdata1, exp_rd1);
        end
      end
    end
  end

  // Uncontended access on the round-robin instance, checked beat by beat.
  // Called just after a rising edge with the arbiter idle.
  task automatic run_access(input logic p, input logic w, input logic [AW-1:0] a, input logic [31:0] d);
    logic [31:0]   g;
    logic [AW-1:0] ak;
    g = p ? 32'd2 : 32'd1;
    if (p) begin
      req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
    end else begin
      req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    end
    sb_push(p, w, a, d);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ak = a + AW'(k);
      check("xfer_addr", 32'(mem_addr), 32'(ak));
      check("xfer_we", 32'(mem_we), 32'(w));
      check("xfer_wdata", 32'(mem_wdata), w ? 32'(d[31-8*k -: 8]) : 32'd0);
      check("xfer_gnt", 32'(gnt), g);
      check("xfer_busy", 32'(busy), 32'd1);
      check("xfer_no_done", 32'({done1, done0}), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    check("done_pulse", 32'({done1, done0}), g);
    check("done_gnt", 32'(gnt), g);
    check("done_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
    if (p) req1 = 1'b0;
    else   req0 = 1'b0;
    @(negedge clk);
    check("idle_done", 32'({done1, done0}), 32'd0);
    check("idle_gnt", 32'(gnt), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Wait, within a bound, for a done pulse on one port of either instance.
  task automatic wait_done(input bit fp, input logic p, input int exp_cyc, input string tag);
    int   cyc;
    logic dp, dq;
    cyc = 0;
    dp  = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      dp = fp ? (p ? f_done1 : f_done0) : (p ? done1 : done0);
    end while (!dp && cyc < 40);
    dq = fp ? (p ? f_done0 : f_done1) : (p ? done0 : done1);
    check(tag, 32'(cyc), 32'(exp_cyc));
    check({tag, "_other"}, 32'(dq), 32'd0);
    check({tag, "_gnt"}, 32'(fp ? f_gnt : gnt), p ? 32'd2 : 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = 32'h0; wdata1 = 32'h0;
    f_req0 = 1'b0; f_req1 = 1'b0; f_we0 = 1'b0; f_we1 = 1'b0;
    f_addr0 = '0; f_addr1 = '0; f_wdata0 = 32'h0; f_wdata1 = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'({done1, done0}), 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    @(posedge clk);
    #1;

    // Basic write / read-back, then a write and read across the address wrap
    run_access(1'b0, 1'b1, 5'd4, 32'hDEAD_BEEF);
    run_access(1'b1, 1'b0, 5'd4, 32'h0);
    run_access(1'b0, 1'b1, 5'd30, 32'h1122_3344);
    check("wrap_byte0", 32'(mem[0]), 32'h33);
    check("wrap_byte31", 32'(mem[31]), 32'h22);
    run_access(1'b1, 1'b0, 5'd30, 32'h0);

    // Simultaneous requests with last=1: port 0 first, port 1 at next IDLE
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd12; wdata0 = 32'hCAFE_F00D;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd12;
    sb_push(1'b0, 1'b1, 5'd12, 32'hCAFE_F00D);
    sb_push(1'b1, 1'b0, 5'd12, 32'h0);
    wait_done(1'b0, 1'b0, 6, "tie1_p0");
    @(posedge clk); #1 req0 = 1'b0;
    wait_done(1'b0, 1'b1, 6, "tie1_p1");
    @(posedge clk); #1 req1 = 1'b0;
    @(posedge clk); #1;

    // Solo port 0 access leaves last=0, so the next tie goes to port 1
    run_access(1'b0, 1'b0, 5'd12, 32'h0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd4;
    req1 = 1'b1; we1 = 1'b1; addr1 = 5'd20; wdata1 = 32'h5A5A_A5A5;
    sb_push(1'b1, 1'b1, 5'd20, 32'h5A5A_A5A5);
    sb_push(1'b0, 1'b0, 5'd4, 32'h0);
    wait_done(1'b0, 1'b1, 6, "tie2_p1");
    @(posedge clk); #1 req1 = 1'b0;
    wait_done(1'b0, 1'b0, 6, "tie2_p0");
    @(posedge clk); #1 req0 = 1'b0;
    @(posedge clk); #1;

    // Reset lands on the edge that would start beat 2 of a write at addr 8
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd8; wdata0 = 32'hAABB_CCDD;
    @(posedge clk);          // latched, beat 0 follows
    @(posedge clk);          // beat 0 written, beat 1 follows
    #1 reset = 1'b1;
    @(posedge clk);          // beat 1 written, reset sampled
    #1 reset = 1'b0;
    req0 = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_gnt", 32'(gnt), 32'd0);
    check("rst_mid_done", 32'({done1, done0}), 32'd0);
    check("rst_mid_mem_we", 32'(mem_we), 32'd0);
    check("rst_mid_rdata0", rdata0, 32'd0);
    check("rst_mid_byte8", 32'(mem[8]), 32'hAA);
    check("rst_mid_byte9", 32'(mem[9]), 32'hBB);
    check("rst_mid_byte10", 32'(mem[10]), 32'h00);
    check("rst_mid_byte11", 32'(mem[11]), 32'h00);
    ref_mem[8] = 8'hAA;
    ref_mem[9] = 8'hBB;
    exp_rd0 = 32'h0;
    exp_rd1 = 32'h0;
    @(posedge clk); #1;
    run_access(1'b1, 1'b0, 5'd8, 32'h0);

    // Fixed priority: req0 held continuously wins every tie
    f_req0 = 1'b1; f_we0 = 1'b1; f_addr0 = 5'd0; f_wdata0 = 32'h0102_0304;
    f_req1 = 1'b1; f_we1 = 1'b1; f_addr1 = 5'd16; f_wdata1 = 32'h9988_7766;
    for (int i = 0; i < 3; i++) begin
      wait_done(1'b1, 1'b0, 6, "fp_p0");
    end
    @(posedge clk); #1 f_req0 = 1'b0;
    wait_done(1'b1, 1'b1, 6, "fp_p1");
    check("fp_byte16", 32'(fmem[16]), 32'h99);
    check("fp_byte19", 32'(fmem[19]), 32'h66);
    check("fp_byte3", 32'(fmem[3]), 32'h04);
    @(posedge clk); #1 f_req1 = 1'b0;
    repeat (2) @(posedge clk);

    @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("end_busy", 32'(busy), 32'd0);
    check("end_fp_busy", 32'(f_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single byte-wide data memory (32 x 8) between two word requesters: port 0 is the processor load/store path and port 1 is the loader/debug path.
- Each granted word access is sequenced as four byte beats in big-endian order. The byte at the base address carries bits 31:24.
- Arbitration is round-robin by default and fixed-priority to port 0 by parameter.
- Sits between the requesters and the datmem byte array; it replaces direct multi-byte indexing of the array.

Parameters:
- ADDR_W, 5, byte address width; memory depth is 2**ADDR_W; address arithmetic wraps modulo 2**ADDR_W.
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins simultaneous requests.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  access request per port; held high until done.
- we0 / we1  in  1  1 = word write, 0 = word read; stable while req is high.
- addr0 / addr1  in  ADDR_W  byte base address; stable while req is high.
- wdata0 / wdata1  in  32  write word; stable while req is high.
- done0 / done1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  32  read word; valid from the done cycle and held until the next read done on that port.
- gnt  out  2  one-hot owner; nonzero in XFER and DONE only.
- busy  out  1  high when state is not IDLE.
- mem_addr  out  ADDR_W  byte address to the memory.
- mem_we  out  1  byte write strobe.
- mem_wdata  out  8  byte write data.
- mem_rdata  in  8  byte read data, combinational from mem_addr.

Behaviour:
- Reset values: state IDLE, gnt=0, busy=0, done0=done1=0, rdata0=rdata1=0, mem_we=0, mem_addr=0, mem_wdata=0, beat=0. The round-robin pointer last=1, so port 0 wins the first tie.
- FSM states are IDLE, XFER, DONE.
  - IDLE: if no req, stay. If exactly one req, that port wins. If both req, the winner is port 0 when FIXED_PRIO=1, otherwise the port not equal to last.
  - On the edge leaving IDLE: latch owner, we, addr, and wdata from the winning port; set beat=0; go to XFER.
  - XFER: one beat per cycle, beat 0..3.
    - mem_addr = latched addr + beat, truncated to ADDR_W bits, so 31+1 wraps to 0.
    - Write: mem_we=1; mem_wdata = wdata[31:24], [23:16], [15:8], [7:0] for beats 0..3.
    - Read: mem_we=0; mem_rdata is shifted into the byte accumulator at each beat edge.
    - After beat 3, go to DONE.
  - DONE: one cycle.
    - done of the owner = 1.
    - On a read, that port's rdata shows the assembled word this cycle and holds it afterwards.
    - On a write, rdata is unchanged.
    - last = owner. Next state is IDLE.
- mem_we, mem_addr, and mem_wdata are 0 outside XFER.
- Latency: req first seen in IDLE at cycle T gives XFER in T+1..T+4 and done in T+5. The occupancy is 6 cycles per access including IDLE.
- Handshake: the requester drops req in the cycle after done. req is not sampled in XFER or DONE. A req still high in IDLE is a new access.
- The losing requester keeps req high. It is granted at the next IDLE, which is guaranteed in round-robin mode.
- Changing addr, we, or wdata while req is high has no effect once latched. Dropping req mid-access does not abort the access.
- Reset mid-access: return to the reset values on the next edge with no done pulse. Bytes already written stay in memory; there is no rollback.
- Simultaneous done on one port and a new req on the other: the new req is served from the following IDLE.

Test Plan:
- Port 0 write, addr0=4, wdata0=0xDEADBEEF -> mem writes DE@4, AD@5, BE@6, EF@7 in T+1..T+4; done0 at T+5 only; gnt=01 during T+1..T+5.
- Port 1 read, addr1=4, after the write above -> rdata1=0xDEADBEEF at done1; rdata0 unchanged.
- Wrap: port 0 write at addr0=30, wdata0=0x11223344 -> bytes land at 30, 31, 0, 1.
- Both req in the same cycle after reset, FIXED_PRIO=0 -> port 0 served first, port 1 granted at the next IDLE. A second simultaneous pair -> port 1 first.
- FIXED_PRIO=1 with req0 held continuously and req1 waiting -> port 0 wins every tie; port 1 is served only when req0 is low in IDLE.
- reset asserted during beat 2 of a write at addr 8 with 0xAABBCCDD -> AA@8 and BB@9 are written, CC and DD are not. No done pulse; busy=0 and gnt=0 the next cycle; state IDLE.
